// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port between NUM_REQUESTERS masters, one transfer per grant.
// Optional: define XADC_DRP_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without drdy.
module xadc_drp_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 xadc_dclk,
  input  logic                                 xadc_reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  input  logic [NUM_REQUESTERS-1:0]            req_we,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_di,
  output logic [NUM_REQUESTERS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 rsp_error,
  output logic                                 busy,
  output logic [ADDR_WIDTH-1:0]                xadc_daddr,
  output logic                                 xadc_den,
  output logic                                 xadc_dwe,
  output logic [DATA_WIDTH-1:0]                xadc_di,
  input  logic [DATA_WIDTH-1:0]                xadc_do,
  input  logic                                 xadc_drdy
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  ptr_t                      rr_q, rr_d;
  ptr_t                      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]     daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0]     di_q, di_d;
  logic                      den_q, den_d;
  logic                      dwe_q, dwe_d;
  logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;

`ifdef XADC_DRP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_error_q, rsp_error_d;
`endif

  ptr_t                      winner;
  logic                      grant_found;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_di;
  logic                      sel_we;
  logic [NUM_REQUESTERS-1:0] owner_onehot;

  // Rotating priority: first pass looks at indices at or above the pointer,
  // second pass wraps around to the lowest valid index.
  always_comb begin : arbitrate
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    grant_found  = 1'b0;
    winner       = '0;
    req_ready    = '0;
    sel_addr     = '0;
    sel_di       = '0;
    sel_we       = 1'b0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!grant_found && req_valid[i] && (ptr_t'(i) >= rr_q)) begin
        grant_found = 1'b1;
        winner      = ptr_t'(i);
      end
    end
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        winner      = ptr_t'(i);
      end
    end
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (ptr_t'(i) == winner) begin
        req_ready[i] = grant_found && (state_q == S_IDLE);
        sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_di       = req_di[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we       = req_we[i];
      end
      owner_onehot[i] = (ptr_t'(i) == owner_q);
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    daddr_d     = daddr_q;
    di_d        = di_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_error_d = rsp_error_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_ISSUE;
          owner_d = winner;
          rr_d    = (winner == ptr_t'(NUM_REQUESTERS - 1)) ? '0 : winner + 1'b1;
          daddr_d = sel_addr;
          di_d    = sel_di;
          den_d   = 1'b1;
          dwe_d   = sel_we;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // drdy is checked first so a completion on the expiry cycle still wins.
        if (xadc_drdy) begin
          state_d     = S_IDLE;
          rsp_data_d  = xadc_do;
          rsp_valid_d = owner_onehot;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
          rsp_error_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          rsp_data_d  = '0;
          rsp_valid_d = owner_onehot;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge xadc_dclk) begin
    // NOTE: non-blocking assignments make every flop sample its pre-edge inputs, independent of statement order.
    if (xadc_reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      daddr_q     <= '0;
      di_q        <= '0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

`ifdef XADC_DRP_ARB_TIMEOUT_EN
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != S_IDLE);
  assign xadc_daddr = daddr_q;
  assign xadc_di    = di_q;
  assign xadc_den   = den_q;
  assign xadc_dwe   = dwe_q;

endmodule

// File: doc/xadc_drp_arbiter.md
Name: xadc_drp_arbiter

Overview:
- Shares the single XADC DRP port between NUM_REQUESTERS independent masters, e.g. the channel-read adapter and a runtime configuration writer.
- Grants requesters round-robin and issues one DRP read or write per grant (single-cycle den pulse).
- Waits for drdy and returns the read data to the granted requester only.
- Sits between the requesters and the XADC IP in the xadc_dclk domain.

Parameters:
NUM_REQUESTERS, 2, number of DRP masters (>=2)
ADDR_WIDTH, 7, DRP address width
DATA_WIDTH, 16, DRP data width
TIMEOUT_CYCLES, 64, WAIT-state cycles before abort (used only with XADC_DRP_ARB_TIMEOUT_EN; >=2)

Ports:
xadc_dclk  input  1  clock; all logic on rising edge
xadc_reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQUESTERS  per-requester transaction request
req_ready  output  NUM_REQUESTERS  per-requester accept, combinational
req_we  input  NUM_REQUESTERS  1 = write, 0 = read
req_addr  input  NUM_REQUESTERS*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_di  input  NUM_REQUESTERS*DATA_WIDTH  packed write data, same packing
rsp_valid  output  NUM_REQUESTERS  one-cycle completion pulse to owner
rsp_data  output  DATA_WIDTH  captured do, shared across requesters
rsp_error  output  1  qualifies rsp_valid; 1 = timed out
busy  output  1  high in ISSUE and WAIT
xadc_daddr  output  ADDR_WIDTH  DRP address
xadc_den  output  1  DRP enable pulse
xadc_dwe  output  1  DRP write enable
xadc_di  output  DATA_WIDTH  DRP write data
xadc_do  input  DATA_WIDTH  DRP read data
xadc_drdy  input  1  DRP completion

Behaviour:
- Reset values:
  - state = IDLE; rr pointer = 0; owner = 0.
  - xadc_den, xadc_dwe = 0; xadc_daddr, xadc_di = 0.
  - rsp_valid = 0; rsp_data = 0; rsp_error = 0.
  - Wait counter = 0.
- Reset mid-transaction: abandons the transaction, no rsp_valid. A drdy arriving after reset is ignored.
- States:
  - IDLE -> ISSUE: on any req_valid.
  - ISSUE -> WAIT: unconditional.
  - WAIT -> IDLE: on drdy, or on timeout when XADC_DRP_ARB_TIMEOUT_EN is defined.
- Arbitration (IDLE only):
  - Winner = first i with req_valid[i], searching from rr pointer upward modulo NUM_REQUESTERS.
  - req_ready[winner] = 1 combinationally; all other req_ready = 0. req_ready is 0 in ISSUE and WAIT.
  - Transfer happens when req_valid & req_ready. On that edge:
    - latch addr, we, di into the DRP outputs;
    - owner <= winner; rr pointer <= (winner + 1) mod N;
    - xadc_den <= 1; xadc_dwe <= req_we[winner].
- ISSUE: xadc_den and xadc_dwe are high for exactly this one cycle, then return to 0. daddr and di hold until the next grant.
- WAIT:
  - On xadc_drdy: rsp_data <= xadc_do; rsp_error <= 0; rsp_valid[owner] <= 1 for one cycle; state -> IDLE.
  - Writes complete the same way; rsp_data is then don't-care.
- Latency:
  - Accept at cycle 0, den at cycle 1, drdy at cycle k (k >= 2), rsp_valid at cycle k+1.
  - A new grant may occur in the same cycle as rsp_valid, giving back-to-back transactions every k+1 cycles.
- Ignored inputs:
  - drdy while in IDLE or ISSUE is ignored.
  - req_valid dropped before acceptance is legal; no grant is recorded.
- No response backpressure: a requester must sample rsp_valid when it pulses.
- Simultaneous requests: exactly one grant per IDLE cycle. The losing request stays pending and wins the next grant if still valid (fairness). With N=2 and both requests continuously valid, grants alternate 0,1,0,1.

Optional Feature:
Macro XADC_DRP_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without drdy.
  - When it reaches TIMEOUT_CYCLES: rsp_valid[owner] = 1, rsp_error = 1, rsp_data = 0, state -> IDLE.
  - drdy in the same cycle as expiry wins and is treated as a normal completion.
  - A later stray drdy is ignored.
- Undefined: no counter; WAIT persists until drdy; rsp_error is tied to 0.

Test Plan:
- Single read: reset, req_valid[0] with addr 0x03 and we=0 -> req_ready[0] pulses; den=1 for one cycle with daddr=0x03, dwe=0. Model drdy 3 cycles later with do=0xA5C0 -> rsp_valid[0]=1 for one cycle, rsp_data=0xA5C0, rsp_valid[1]=0.
- Write: req_valid[1] with addr 0x41, we=1, di=0x2000 -> den=1, dwe=1, di=0x2000 for one cycle; rsp_valid[1] follows drdy.
- Contention: req_valid[0] and req_valid[1] held high for 4 transactions -> grant order 0,1,0,1. rsp_valid always goes to the matching owner, and den never pulses while busy.
- Stray/reset: drdy in IDLE -> no rsp_valid. Reset asserted in WAIT, then drdy -> no rsp_valid, den=0, and the next grant goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): grant with no drdy -> rsp_valid with rsp_error=1 and rsp_data=0 exactly 8 WAIT cycles after ISSUE; a late drdy is ignored. Drdy on the expiry cycle -> normal response with rsp_error=0.
- Timeout (macro undefined): no drdy for 1000 cycles -> busy stays 1, no rsp_valid; drdy then completes normally.
